ram_bubble_sorter: RTL and testbench
====================================

# ram_bubble_sorter

Upstream loader stage for the binary-search datapath. It sorts the 32x8 single-port RAM in place, in ascending order, using an early-terminating bubble sort. It then raises `done` so the search controller can be started on guaranteed-sorted contents. It owns the RAM address, write-data and write-enable lines while `busy` is high. The top level muxes those lines back to the search datapath when `busy` is low.

## Interface
Parameters:
- `DEPTH`, 32: number of RAM words sorted, addresses 0..DEPTH-1; DEPTH ≥ 2.
- `ADDR_W`, 5: address width; 2^ADDR_W ≥ DEPTH.
- `DATA_W`, 8: word width; values compared unsigned.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low (0 = reset); one clock; reset is asynchronous and active-low.
- `start`  in  1  level input (held key); a sort begins on its rising edge.
- `rdata`  in  DATA_W  RAM `q`; valid one cycle after `addr` is presented (registered read).
- `addr`  out  ADDR_W  RAM address.
- `wdata`  out  DATA_W  RAM write data.
- `wren`  out  1  RAM write enable.
- `busy`  out  1  high while sorting.
- `done`  out  1  high from sort completion until the next accepted start or reset.

## Operation
- Start detection: `start` is registered into `start_q`. A rising edge means `start`=1 and `start_q`=0.
  - Accepted only in IDLE or DONE.
  - Ignored while `busy`.
  - A held `start` triggers exactly one sort.
- Registers:
  - `i`: current low index.
  - `last`: highest index compared this pass; initialised to DEPTH-1, decremented each pass.
  - `a`, `b`: captured words.
  - `swapped`: pass flag.
- States:
  - IDLE: on start edge, set `i`=0, `last`=DEPTH-1, `swapped`=0, go to RD_LO.
  - RD_LO: `addr`=i; go to RD_HI.
  - RD_HI: `addr`=i+1; capture `a`=rdata (A[i]); go to CMP.
  - CMP: capture `b`=rdata (A[i+1]).
    - If A[i] > A[i+1], go to WR_LO.
    - Otherwise, if i+1 = last go to PASS_END; else set i=i+1 and go to RD_LO.
  - WR_LO: `addr`=i, `wdata`=b, `wren`=1; set `swapped`=1; go to WR_HI.
  - WR_HI: `addr`=i+1, `wdata`=a, `wren`=1; then the same advance rule as CMP's no-swap branch.
  - PASS_END:
    - If `swapped`=0 or `last`=1, go to DONE.
    - Otherwise set `last`=last-1, `i`=0, `swapped`=0, go to RD_LO.
  - DONE: `done`=1; a start edge re-enters the IDLE start actions, with `done` cleared.
- Equal words are never swapped, so the sort is stable and duplicates cause no writes.
- Outputs are Moore-decoded from state, `i`, `a` and `b`.
- `addr`=0, `wdata`=0 and `wren`=0 in IDLE, DONE and PASS_END.
- `busy`=1 in RD_LO, RD_HI, CMP, WR_LO, WR_HI and PASS_END.

## Timing
- Reset asserted (asynchronous, immediate):
  - state=IDLE; `addr`=0, `wdata`=0, `wren`=0, `busy`=0, `done`=0.
  - All registers cleared.
  - Mid-sort reset leaves the RAM partially sorted; no restore.
- The start edge is sampled at clock edge E0; RD_LO is entered at E0 and `busy` rises after E0.
- Per compare: 3 cycles without a swap, 5 with a swap. PASS_END is 1 cycle per pass.
- Already-sorted DEPTH=32: one pass, 31×3+1 = 94 cycles; DONE is entered at E0+94.
- Strictly descending DEPTH=32: 31 passes, 496 swaps; 496×5+31 = 2511 cycles.
- No cycle has `wren`=1 outside WR_LO and WR_HI. Each write lasts exactly one cycle.
- Index arithmetic is ADDR_W bits wide. `i+1` never exceeds `last`, so there is no wrap-around.

## Configuration
- `SORT_SWAP_COUNT_EN`:
  - Defined: adds output `swap_count` (10 bits). It is cleared on reset and on an accepted start, and increments by 1 in each WR_LO. It holds its value in DONE; it equals 496 after a descending 32-word sort.
  - Undefined: no port, no counter logic; all other behaviour is identical.

## Test plan
- RAM preloaded 0..31 ascending, start pulse → `wren` never 1, `done`=1 at E0+94, RAM unchanged.
- RAM preloaded 31..0 → `done` at E0+2511; RAM reads 0..31; `swap_count`=496 with the macro defined.
- All 32 words = 8'h55 → no writes, `done` at E0+94.
- Random words including duplicates → RAM ends non-decreasing and is a permutation of the input (multiset check). `start` held high for 3000 cycles → exactly one sort; a second edge after `done` re-sorts with zero writes.
- Reset driven low during WR_LO → `wren`, `busy` and `addr` go to 0 without waiting for a clock edge; state=IDLE; `done`=0.
- Start edge while `busy` → ignored; completion cycle count is unchanged from the unperturbed run.

Source files
------------

// File: rtl/ram_bubble_sorter.sv
// ram_bubble_sorter
// In-place ascending bubble sort of a DEPTH x DATA_W single-port RAM with a
// registered read port. Each pass walks adjacent pairs from address 0 up to
// `last`, swapping out-of-order pairs. The sort stops early after a pass with
// no swap, or once the final pair (last=1) has been handled.
//
// Optional feature macro: SORT_SWAP_COUNT_EN adds a 10-bit `swap_count` output
// that counts swaps of the most recent sort.
//
// Start/done protocol: `start` is a level input. A sort begins on its rising
// edge (start=1 while the registered copy is 0), but only in IDLE or DONE.
// `busy` is high for the whole sort. While `busy` is high this block owns the
// RAM addr/wdata/wren lines. `done` stays high from completion until the
// next accepted start or reset.
//
// dbg_state encoding: 0 IDLE, 1 RD_LO, 2 RD_HI, 3 CMP, 4 WR_LO, 5 WR_HI,
// 6 PASS_END, 7 DONE.
module ram_bubble_sorter #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              wren,
    output logic              busy,
    output logic              done,
`ifdef SORT_SWAP_COUNT_EN
    output logic [9:0]        swap_count,
`endif
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_LO    = 3'd1,
        RD_HI    = 3'd2,
        CMP      = 3'd3,
        WR_LO    = 3'd4,
        WR_HI    = 3'd5,
        PASS_END = 3'd6,
        DONE     = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_INIT = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_t            state;
    logic              start_q;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] last;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              swapped;

    logic [ADDR_W-1:0] i_next;
    logic              start_edge;
    logic              pair_is_last;

    assign i_next       = i + ONE;
    assign start_edge   = start & ~start_q;
    // i+1 never passes `last`, so equality marks the final pair of a pass.
    assign pair_is_last = (i_next == last);

    // Sort sequencer: start-edge register, index/bound registers and captured words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            i       <= '0;
            last    <= '0;
            a       <= '0;
            b       <= '0;
            swapped <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        i       <= '0;
                        last    <= LAST_INIT;
                        swapped <= 1'b0;
                        state   <= RD_LO;
                    end
                end
                RD_LO: begin
                    state <= RD_HI;
                end
                RD_HI: begin
                    // rdata now holds A[i], the word addressed in RD_LO.
                    a     <= rdata;
                    state <= CMP;
                end
                CMP: begin
                    // rdata now holds A[i+1]. Equal words stay put, which keeps the sort stable.
                    b <= rdata;
                    if (a > rdata) begin
                        state <= WR_LO;
                    end else if (pair_is_last) begin
                        state <= PASS_END;
                    end else begin
                        i     <= i_next;
                        state <= RD_LO;
                    end
                end
                WR_LO: begin
                    swapped <= 1'b1;
                    state   <= WR_HI;
                end
                WR_HI: begin
                    if (pair_is_last) begin
                        state <= PASS_END;
                    end else begin
                        i     <= i_next;
                        state <= RD_LO;
                    end
                end
                PASS_END: begin
                    // A clean pass, or a pass that covered only the last pair, means the RAM is sorted.
                    if (!swapped || last == ONE) begin
                        state <= DONE;
                    end else begin
                        last    <= last - ONE;
                        i       <= '0;
                        swapped <= 1'b0;
                        state   <= RD_LO;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SORT_SWAP_COUNT_EN
    // Swap counter: cleared on an accepted start, bumped once per WR_LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            swap_count <= '0;
        end else if ((state == IDLE || state == DONE) && start_edge) begin
            swap_count <= '0;
        end else if (state == WR_LO) begin
            swap_count <= swap_count + 10'd1;
        end
    end
`endif

    // Moore output decode from state, i, a and b only.
    always_comb begin
        addr      = '0;
        wdata     = '0;
        wren      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        dbg_state = state;
        case (state)
            RD_LO: begin
                addr = i;
                busy = 1'b1;
            end
            RD_HI: begin
                addr = i_next;
                busy = 1'b1;
            end
            CMP: begin
                busy = 1'b1;
            end
            WR_LO: begin
                addr  = i;
                wdata = b;
                wren  = 1'b1;
                busy  = 1'b1;
            end
            WR_HI: begin
                addr  = i_next;
                wdata = a;
                wren  = 1'b1;
                busy  = 1'b1;
            end
            PASS_END: begin
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_bubble_sorter.sv
// Bench for ram_bubble_sorter: behavioural 32x8 RAM with registered read,
// directed sort scenarios with hand-derived cycle counts and write counts.
module tb_ram_bubble_sorter;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wren;
    logic              busy;
    logic              done;
    logic [2:0]        dbg_state;
`ifdef SORT_SWAP_COUNT_EN
    logic [9:0]        swap_count;
`endif

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ref_in [DEPTH];
    int                wr_cnt;
    int                n_checks;
    int                n_pass;

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_bubble_sorter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .rdata     (rdata),
        .addr      (addr),
        .wdata     (wdata),
        .wren      (wren),
        .busy      (busy),
        .done      (done),
`ifdef SORT_SWAP_COUNT_EN
        .swap_count(swap_count),
`endif
        .dbg_state (dbg_state)
    );

    // RAM model: synchronous write, registered read (old data on collision)
    always @(posedge clk) begin
        if (wren) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

    // write counter, sampled mid-cycle
    always @(negedge clk) begin
        if (wren) wr_cnt++;
    end

    // Pulse start (or keep it for `poke` pulses), count edges after E0 until done.
    task automatic run_sort(input int poke, output int cycles, output int writes,
                            output logic busy_e0);
        int base;
        base   = wr_cnt;
        cycles = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        busy_e0 = busy;
        start   = 1'b0;
        for (int n = 1; n <= 6000; n++) begin
            @(posedge clk);
            #1;
            if (poke != 0 && n == poke)     start = 1'b1;
            if (poke != 0 && n == poke + 3) start = 1'b0;
            if (done) begin
                cycles = n;
                break;
            end
        end
        start  = 1'b0;
        writes = wr_cnt - base;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        #23;
        n_checks++;
        if ({addr, wdata, wren, busy, done} !== '0) $display("FAIL reset_outputs got addr=%0d wdata=%0d wren=%0b busy=%0b done=%0b need all 0", addr, wdata, wren, busy, done);
        else n_pass++;
        n_checks++;
        if (dbg_state !== 3'd0) $display("FAIL reset_state got %0d need 0", dbg_state);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sorted();
        int c, w;
        logic be;
        int bad;
        for (int k = 0; k < DEPTH; k++) mem[k] = DATA_W'(k);
        run_sort(0, c, w, be);
        n_checks++;
        if (be !== 1'b1) $display("FAIL sorted_busy_after_e0 got %0b need 1", be);
        else n_pass++;
        n_checks++;
        if (c !== 94) $display("FAIL sorted_cycles got %0d need 94", c);
        else n_pass++;
        n_checks++;
        if (w !== 0) $display("FAIL sorted_writes got %0d need 0", w);
        else n_pass++;
        bad = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== DATA_W'(k)) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL sorted_contents got %0d wrong words need 0", bad);
        else n_pass++;
    endtask

    task automatic test_descending();
        int c, w;
        logic be;
        int bad;
        for (int k = 0; k < DEPTH; k++) mem[k] = DATA_W'(31 - k);
        run_sort(0, c, w, be);
        n_checks++;
        if (c !== 2511) $display("FAIL desc_cycles got %0d need 2511", c);
        else n_pass++;
        n_checks++;
        if (w !== 992) $display("FAIL desc_writes got %0d need 992", w);
        else n_pass++;
        bad = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== DATA_W'(k)) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL desc_contents got %0d wrong words need 0", bad);
        else n_pass++;
`ifdef SORT_SWAP_COUNT_EN
        n_checks++;
        if (swap_count !== 10'd496) $display("FAIL desc_swap_count got %0d need 496", swap_count);
        else n_pass++;
`endif
    endtask

    task automatic test_all_equal();
        int c, w;
        logic be;
        for (int k = 0; k < DEPTH; k++) mem[k] = 8'h55;
        run_sort(0, c, w, be);
        n_checks++;
        if (c !== 94) $display("FAIL equal_cycles got %0d need 94", c);
        else n_pass++;
        n_checks++;
        if (w !== 0) $display("FAIL equal_writes got %0d need 0", w);
        else n_pass++;
    endtask

    task automatic test_dups_held_start();
        int hist [256];
        int rises, bad_order, bad_set, base;
        logic prev_busy;
        for (int k = 0; k < DEPTH; k++) begin
            mem[k]    = DATA_W'(((k * 7) % 10) * 20 + ((k % 3 == 0) ? 5 : 0));
            ref_in[k] = mem[k];
        end
        for (int v = 0; v < 256; v++) hist[v] = 0;
        for (int k = 0; k < DEPTH; k++) hist[ref_in[k]]++;
        rises     = 0;
        prev_busy = 1'b0;
        base      = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (rises !== 1) $display("FAIL held_start_sorts got %0d need 1", rises);
        else n_pass++;
        n_checks++;
        if (done !== 1'b1) $display("FAIL held_start_done got %0b need 1", done);
        else n_pass++;
        n_checks++;
        if (wr_cnt - base == 0) $display("FAIL held_start_writes got 0 need nonzero");
        else n_pass++;
        bad_order = 0;
        for (int k = 0; k < DEPTH - 1; k++) if (mem[k] > mem[k+1]) bad_order++;
        n_checks++;
        if (bad_order !== 0) $display("FAIL dups_order got %0d inversions need 0", bad_order);
        else n_pass++;
        for (int k = 0; k < DEPTH; k++) hist[mem[k]]--;
        bad_set = 0;
        for (int v = 0; v < 256; v++) if (hist[v] != 0) bad_set++;
        n_checks++;
        if (bad_set !== 0) $display("FAIL dups_multiset got %0d differing values need 0", bad_set);
        else n_pass++;
    endtask

    task automatic test_resort();
        int c, w;
        logic be;
        run_sort(0, c, w, be);
        n_checks++;
        if (c !== 94) $display("FAIL resort_cycles got %0d need 94", c);
        else n_pass++;
        n_checks++;
        if (w !== 0) $display("FAIL resort_writes got %0d need 0", w);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        logic seen;
        for (int k = 0; k < DEPTH; k++) mem[k] = DATA_W'(31 - k);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (dbg_state == 3'd4) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (seen !== 1'b1) $display("FAIL midreset_reach_wr_lo got 0 need 1");
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wren, busy, addr, done} !== '0) $display("FAIL midreset_outputs got wren=%0b busy=%0b addr=%0d done=%0b need 0", wren, busy, addr, done);
        else n_pass++;
        n_checks++;
        if (dbg_state !== 3'd0) $display("FAIL midreset_state got %0d need 0", dbg_state);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_start_ignored();
        int c0, c1, w0, w1;
        logic be;
        int bad;
        for (int k = 0; k < DEPTH; k++) mem[k] = DATA_W'((k * 13 + 7) % 32);
        run_sort(0, c0, w0, be);
        for (int k = 0; k < DEPTH; k++) mem[k] = DATA_W'((k * 13 + 7) % 32);
        run_sort(10, c1, w1, be);
        n_checks++;
        if (c1 !== c0 || c0 < 94) $display("FAIL busy_start_cycles got %0d need %0d", c1, c0);
        else n_pass++;
        n_checks++;
        if (w1 !== w0) $display("FAIL busy_start_writes got %0d need %0d", w1, w0);
        else n_pass++;
        bad = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== DATA_W'(k)) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL busy_start_contents got %0d wrong words need 0", bad);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        wr_cnt   = 0;
        start    = 1'b0;
        rst_n    = 1'b0;
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;
        test_reset();
        test_sorted();
        test_descending();
        test_all_equal();
        test_dups_held_start();
        test_resort();
        test_reset_mid_write();
        test_busy_start_ignored();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
